// File: rtl/cam_pixel_writer.sv
// cam_pixel_writer: places the camera's RGB332 pixel stream into the M9K frame buffer
// and tallies red/blue pixels per frame for the treasure-colour detector.
module cam_pixel_writer #(
    parameter int unsigned SCREEN_WIDTH  = 176,
    parameter int unsigned SCREEN_HEIGHT = 144,
    parameter int unsigned ADDR_W        = 15,
    parameter int unsigned CNT_W         = 15
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              VSYNC,
    input  logic              HREF,
    input  logic [7:0]        pixel_data,
    input  logic              pixel_valid,
    output logic [ADDR_W-1:0] W_ADDR,
    output logic [7:0]        W_DATA,
    output logic              W_EN,
    output logic              FRAME_DONE,
    output logic [CNT_W-1:0]  RED_COUNT,
    output logic [CNT_W-1:0]  BLUE_COUNT,
    output logic              OVERRUN
);
    localparam int unsigned X_W = $clog2(SCREEN_WIDTH + 1);
    localparam int unsigned Y_W = $clog2(SCREEN_HEIGHT + 1);
    localparam logic [X_W-1:0]    X_LIM    = X_W'(SCREEN_WIDTH);
    localparam logic [Y_W-1:0]    Y_LIM    = Y_W'(SCREEN_HEIGHT);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SCREEN_WIDTH);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_VBLANK,
        S_ACTIVE
    } state_t;

    state_t            state_q, state_d;
    logic              vsync_d_q;
    logic              href_d1_q, href_d2_q;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [CNT_W-1:0]  red_run_q, red_run_d;
    logic [CNT_W-1:0]  blue_run_q, blue_run_d;
    logic              ovr_run_q, ovr_run_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [7:0]        w_data_q, w_data_d;
    logic              w_en_q, w_en_d;
    logic              frame_done_q, frame_done_d;
    logic [CNT_W-1:0]  red_count_q, red_count_d;
    logic [CNT_W-1:0]  blue_count_q, blue_count_d;
    logic              overrun_q, overrun_d;

    logic [2:0] pix_r, pix_g;
    logic [1:0] pix_b;
    logic       is_red, is_blue;
    logic       vsync_rise, vsync_fall, line_end, in_bounds;

    assign {pix_r, pix_g, pix_b} = pixel_data;
    assign is_red     = (pix_r >= 3'd5) && (pix_g <= 3'd2) && (pix_b <= 2'd1);
    assign is_blue    = (pix_b == 2'd3) && (pix_r <= 3'd2) && (pix_g <= 3'd3);
    assign vsync_rise = ~vsync_d_q & VSYNC;
    assign vsync_fall = vsync_d_q & ~VSYNC;
    // HREF is delayed two stages so the capture unit's trailing strobe lands before line end
    assign line_end   = ~href_d1_q & href_d2_q;
    assign in_bounds  = (x_q < X_LIM) && (y_q < Y_LIM);

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        row_base_d   = row_base_q;
        red_run_d    = red_run_q;
        blue_run_d   = blue_run_q;
        ovr_run_d    = ovr_run_q;
        w_addr_d     = w_addr_q;
        w_data_d     = w_data_q;
        w_en_d       = 1'b0;
        frame_done_d = 1'b0;
        red_count_d  = red_count_q;
        blue_count_d = blue_count_q;
        overrun_d    = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (VSYNC) state_d = S_VBLANK;
            end
            S_VBLANK: begin
                if (vsync_fall) begin
                    state_d    = S_ACTIVE;
                    x_d        = '0;
                    y_d        = '0;
                    row_base_d = '0;
                    red_run_d  = '0;
                    blue_run_d = '0;
                    ovr_run_d  = 1'b0;
                end
            end
            S_ACTIVE: begin
                if (pixel_valid) begin
                    if (in_bounds) begin
                        w_en_d   = 1'b1;
                        w_addr_d = row_base_q + ADDR_W'(x_q);
                        w_data_d = pixel_data;
                        x_d      = x_q + 1'b1;
                        if (is_red && (red_run_q != CNT_MAX))   red_run_d  = red_run_q + 1'b1;
                        if (is_blue && (blue_run_q != CNT_MAX)) blue_run_d = blue_run_q + 1'b1;
                    end else begin
                        ovr_run_d = 1'b1;
                    end
                end
                // Line end overrides the X increment so a coincident pixel lands first
                if (line_end && (x_q != '0)) begin
                    x_d = '0;
                    if (y_q != Y_LIM) begin
                        y_d        = y_q + 1'b1;
                        row_base_d = row_base_q + ROW_STEP;
                    end
                end
                if (vsync_rise) begin
                    state_d      = S_VBLANK;
                    frame_done_d = 1'b1;
                    red_count_d  = red_run_d;
                    blue_count_d = blue_run_d;
                    overrun_d    = ovr_run_d;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            vsync_d_q    <= 1'b0;
            href_d1_q    <= 1'b0;
            href_d2_q    <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            row_base_q   <= '0;
            red_run_q    <= '0;
            blue_run_q   <= '0;
            ovr_run_q    <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            w_en_q       <= 1'b0;
            frame_done_q <= 1'b0;
            red_count_q  <= '0;
            blue_count_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_d_q    <= VSYNC;
            href_d1_q    <= HREF;
            href_d2_q    <= href_d1_q;
            x_q          <= x_d;
            y_q          <= y_d;
            row_base_q   <= row_base_d;
            red_run_q    <= red_run_d;
            blue_run_q   <= blue_run_d;
            ovr_run_q    <= ovr_run_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            w_en_q       <= w_en_d;
            frame_done_q <= frame_done_d;
            red_count_q  <= red_count_d;
            blue_count_q <= blue_count_d;
            overrun_q    <= overrun_d;
        end
    end

    assign W_ADDR     = w_addr_q;
    assign W_DATA     = w_data_q;
    assign W_EN       = w_en_q;
    assign FRAME_DONE = frame_done_q;
    assign RED_COUNT  = red_count_q;
    assign BLUE_COUNT = blue_count_q;
    assign OVERRUN    = overrun_q;

endmodule

// File: doc/cam_pixel_writer.md
Name: cam_pixel_writer

Overview:
- Downstream stage of the camera capture unit.
- Consumes its RGB332 pixel stream (8-bit data plus a one-cycle write strobe), along with the camera HREF and VSYNC timing lines.
- Tracks X/Y position and produces frame-buffer (M9K) write address, data and enable.
- Also accumulates per-frame red and blue pixel counts for treasure-colour detection; these are latched at end of frame for the Arduino interface logic.

Parameters:
SCREEN_WIDTH, 176, pixels per line stored in the frame buffer
SCREEN_HEIGHT, 144, lines per frame stored in the frame buffer
ADDR_W, 15, frame-buffer address width (must cover SCREEN_WIDTH*SCREEN_HEIGHT)
CNT_W, 15, width of the colour counters

Ports:
CLK  in  1  camera pixel clock; all logic on posedge
RESET  in  1  synchronous, active-high reset
VSYNC  in  1  camera frame sync; high = vertical blank
HREF  in  1  camera line valid
pixel_data  in  8  RGB332 pixel from the capture unit ([7:5]=R, [4:2]=G, [1:0]=B)
pixel_valid  in  1  one-cycle strobe; pixel_data is valid when high
W_ADDR  out  ADDR_W  frame-buffer write address
W_DATA  out  8  frame-buffer write data
W_EN  out  1  frame-buffer write enable
FRAME_DONE  out  1  one-cycle pulse when a frame completes
RED_COUNT  out  CNT_W  red-pixel count of the last completed frame
BLUE_COUNT  out  CNT_W  blue-pixel count of the last completed frame
OVERRUN  out  1  sticky flag: a pixel fell outside the frame bounds during the last completed frame

Behaviour:
- Clock and reset: single clock domain (CLK). RESET is synchronous and active-high.
- Reset values:
  - All outputs are 0.
  - State is S_IDLE; X, Y, row_base and the internal counters are 0.
- State machine:
  - S_IDLE: wait for VSYNC=1, then go to S_VBLANK. This discards any partial frame after reset.
  - S_VBLANK: on the VSYNC falling edge (VSYNC_d=1, VSYNC=0), go to S_ACTIVE. Clear X, Y, row_base, the running red/blue counts and the running overrun flag.
  - S_ACTIVE: capture pixels. On the VSYNC rising edge (VSYNC_d=0, VSYNC=1), go to S_VBLANK and perform the end-of-frame actions below.
- Pixel write (S_ACTIVE only):
  - When pixel_valid=1 and X<SCREEN_WIDTH and Y<SCREEN_HEIGHT, register W_ADDR=row_base+X, W_DATA=pixel_data and W_EN=1. Latency is 1 cycle from pixel_valid.
  - X then increments.
  - W_EN is 0 in every other cycle. It is never high for 2 cycles unless pixel_valid is.
  - Out-of-bounds pixel: no write, X does not increment past SCREEN_WIDTH, and the running overrun flag is set.
  - pixel_valid in S_IDLE or S_VBLANK is ignored; no write and no count.
- Line end:
  - Detected as a falling edge of HREF delayed by one register stage (HREF_d1=0, HREF_d2=1), so the capture unit's trailing strobe lands first.
  - On line end, if X>0: X<=0, Y<=Y+1 (saturating at SCREEN_HEIGHT), row_base<=row_base+SCREEN_WIDTH. No multiplier is used.
  - If X=0 (empty line), line end is ignored.
  - If pixel_valid and line end fall in the same cycle, the pixel is written at the current X/Y first; X is then cleared and Y incremented.
- Colour classification (on written pixels only):
  - Red: R>=5, G<=2, B<=1.
  - Blue: B==3, R<=2, G<=3.
  - Running counters saturate at 2^CNT_W-1.
- End of frame (VSYNC rise while in S_ACTIVE):
  - RED_COUNT, BLUE_COUNT and OVERRUN load the running values.
  - FRAME_DONE=1 for exactly 1 cycle.
  - Outputs hold until the next frame completes.
  - A pixel_valid in the same cycle as the VSYNC rise is written and counted before latching.
- RESET mid-frame: returns to S_IDLE, clears the latched outputs, and the next frame is captured only after a complete VSYNC high-low sequence.

Test Plan:
- Reset, then VSYNC 1->0, then one line of 176 strobes with data 0x00..0xAF, then HREF fall -> W_ADDR 0..175 with W_DATA matching, each W_EN 1 cycle after its strobe; the next line starts at W_ADDR 176.
- Full 176x144 frame of 0xE0 (red), then VSYNC rise -> FRAME_DONE 1-cycle pulse, RED_COUNT=25344, BLUE_COUNT=0, OVERRUN=0, last W_ADDR=25343.
- Line with 180 strobes -> only 176 writes, the next line starts at address 176, OVERRUN=1 after frame end.
- Final strobe of a line coincident with the HREF_d1 fall -> pixel written at X=175 of the current row, and the next pixel is written at row_base+176, X=0.
- Frame mixing 100 pixels of 0x03 (blue), 50 pixels of 0xE0 and the remainder 0x49 -> BLUE_COUNT=100, RED_COUNT=50; counts hold through the following frame until its FRAME_DONE.
- RESET asserted at line 70 -> outputs 0; strobes during the rest of that frame produce no W_EN; capture resumes only after the next VSYNC high-to-low transition.
